// File: rtl/hist_bin_reader.sv
// Histogram RAM readout: AXI-Lite register/bin reads plus a full bin-table dump
// over AXI-Stream. The RAM read port is shared between the dump FSM and the host.
module hist_bin_reader #(
    parameter int AXIL_ADDR_WIDTH = 12,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH  = 8,
    parameter int RAM_DATA_WIDTH  = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [RAM_ADDR_WIDTH-1:0]  ram_rd_addr,
    output logic                       ram_rd_en,
    input  logic [RAM_DATA_WIDTH-1:0]  ram_rd_data,
    output logic [RAM_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);
    localparam int NBINS = 1 << RAM_ADDR_WIDTH;
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_CTRL   = AXIL_ADDR_WIDTH'('h000);
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_STATUS = AXIL_ADDR_WIDTH'('h004);
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_NBINS  = AXIL_ADDR_WIDTH'('h008);
    localparam logic [AXIL_ADDR_WIDTH-1:0] BIN_BASE    = AXIL_ADDR_WIDTH'('h400);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [RAM_ADDR_WIDTH:0] LAST_IDX = (RAM_ADDR_WIDTH+1)'(NBINS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPT, SEND} state_t;
    state_t state, state_next;

    logic                       wr_accept, wr_go, ctrl_hit, start, start_soon;
    logic                       ar_accept, ar_go, ar_bin, rd_en, rd_first;
    logic [AXIL_ADDR_WIDTH-1:0] bin_off;
    logic [RAM_ADDR_WIDTH-1:0]  rd_addr;
    logic [AXIL_DATA_WIDTH-1:0] rdata_hold, reg_data;
    logic [1:0]                 reg_resp;
    logic [RAM_ADDR_WIDTH:0]    idx;
    logic                       busy, done;
    logic                       unused_wdata;

    assign unused_wdata = ^s_axi_wdata[AXIL_DATA_WIDTH-1:1];

    assign ctrl_hit      = (s_axi_awaddr == ADDR_CTRL);
    assign wr_go         = s_axi_awvalid && s_axi_wvalid && !wr_accept && !s_axi_bvalid;
    assign start         = wr_accept && ctrl_hit && s_axi_wdata[0] && !busy;
    assign start_soon    = wr_go && ctrl_hit && s_axi_wdata[0];
    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_accept    <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            wr_accept <= wr_go;
            if (wr_accept) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= ctrl_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    assign bin_off = s_axi_araddr - BIN_BASE;
    assign ar_bin  = (s_axi_araddr >= BIN_BASE) && (bin_off[1:0] == 2'b00) &&
                     (bin_off[AXIL_ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] == '0);
    // Bin reads are held off while the dump owns the RAM, including the two
    // cycles in which a start is being accepted, so the port never sees two requests.
    assign ar_go   = s_axi_arvalid && !ar_accept && !rd_en && !s_axi_rvalid &&
                     !(ar_bin && (busy || start || start_soon));
    assign s_axi_arready = ar_accept;

    always_comb begin
        reg_data = '0;
        reg_resp = RESP_SLVERR;
        if (s_axi_araddr == ADDR_STATUS) begin
            reg_data = AXIL_DATA_WIDTH'({done, busy});
            reg_resp = RESP_OKAY;
        end else if (s_axi_araddr == ADDR_NBINS) begin
            reg_data = AXIL_DATA_WIDTH'(NBINS);
            reg_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_accept    <= 1'b0;
            rd_en        <= 1'b0;
            rd_first     <= 1'b0;
            rd_addr      <= '0;
            rdata_hold   <= '0;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            ar_accept <= ar_go;
            rd_en     <= ar_accept && ar_bin;
            if (s_axi_rvalid && s_axi_rready)
                s_axi_rvalid <= 1'b0;
            if (ar_accept) begin
                if (ar_bin) begin
                    rd_addr     <= bin_off[RAM_ADDR_WIDTH+1:2];
                    s_axi_rresp <= RESP_OKAY;
                end else begin
                    s_axi_rvalid <= 1'b1;
                    rdata_hold   <= reg_data;
                    s_axi_rresp  <= reg_resp;
                end
            end
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                rd_first     <= 1'b1;
            end
            // First rvalid cycle forwards the RAM output; keep it for later cycles.
            if (rd_first) begin
                rdata_hold <= AXIL_DATA_WIDTH'(ram_rd_data);
                rd_first   <= 1'b0;
            end
        end
    end

    assign s_axi_rdata = rd_first ? AXIL_DATA_WIDTH'(ram_rd_data) : rdata_hold;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        ram_rd_en   = rd_en;
        ram_rd_addr = rd_addr;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = idx[RAM_ADDR_WIDTH-1:0];
                state_next  = CAPT;
            end
            CAPT:  state_next = SEND;
            SEND:  if (m_axis_tready) state_next = m_axis_tlast ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    idx  <= '0;
                end
                CAPT: begin
                    m_axis_tdata  <= ram_rd_data;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (idx == LAST_IDX);
                end
                SEND: if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    if (m_axis_tlast) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        idx <= idx + (RAM_ADDR_WIDTH+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_bin_reader.sv
// Bench for hist_bin_reader: table-driven register/bin reads, randomized reads
// against an address-map model, and full dumps checked against the RAM contents.
module tb_hist_bin_reader;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready, tready;
    logic [31:0] wdata;
    logic        awready, wready, bvalid, arready, rvalid, ram_rd_en, tvalid, tlast;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, tdata, ram_rd_data;
    logic [7:0]  ram_rd_addr;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem [256];
    logic [31:0] bq_data [$];
    logic        bq_last [$];
    int  cyc = 0;
    int  last_beat_cyc = -100;
    logic stall_prev = 1'b0;
    logic [31:0] d_prev = '0;
    logic l_prev = 1'b0;
    logic rand_mode = 1'b0;

    hist_bin_reader dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    always #5 aclk = ~aclk;

    // Synchronous RAM: data appears the cycle after the read strobe.
    always @(posedge aclk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tvalid_held", tvalid, 1'b1);
                check("tdata_held", tdata, d_prev);
                check("tlast_held", tlast, l_prev);
            end
            if (tvalid && tready) begin
                bq_data.push_back(tdata);
                bq_last.push_back(tlast);
                check("beat_gap_ge3", (cyc - last_beat_cyc) >= 3, 1'b1);
                last_beat_cyc = cyc;
            end
            stall_prev = tvalid && !tready;
            d_prev = tdata;
            l_prev = tlast;
        end
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d,
                                       output logic [1:0] r, output int lat);
        int ai = int'(a);
        d = 0; r = 2'b10; lat = 1;
        if (ai == 4) begin d = 0; r = 2'b00; end
        else if (ai == 8) begin d = 256; r = 2'b00; end
        else if (ai >= 1024 && ai < 1024 + 4 * 256 && ai % 4 == 0) begin
            d = mem[(ai - 1024) / 4]; r = 2'b00; lat = 2;
        end
    endfunction

    task automatic axil_read(input logic [11:0] a, input int hold, output logic [31:0] d,
                             output logic [1:0] r, output int lat, output int acc_beats,
                             output logic en1, output logic [7:0] addr1);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        do begin @(posedge aclk); #1; n++; end while (!arready && n < 4000);
        check("arready_seen", arready, 1'b1);
        acc_beats = bq_data.size();
        @(posedge aclk); #1;
        arvalid = 1'b0;
        lat = 1; en1 = ram_rd_en; addr1 = ram_rd_addr;
        while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
        d = rdata; r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check("rvalid_hold", rvalid, 1'b1);
            check("rdata_hold", rdata, d);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(posedge aclk); #1; n++; end while (!awready && n < 100);
        check("awready_seen", awready, 1'b1);
        check("wready_with_awready", wready, awready);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check("bvalid_next_cycle", n, 0);
        resp = bresp;
        @(posedge aclk); #1;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (bq_data.size() < n && k < 6000) begin @(posedge aclk); #1; k++; end
        check("beats_reached", bq_data.size() >= n, 1'b1);
    endtask

    task automatic compare_dump();
        check("dump_len", bq_data.size(), 256);
        for (int i = 0; i < bq_data.size() && i < 256; i++) begin
            check($sformatf("beat%0d_data", i), bq_data[i], mem[i]);
            check($sformatf("beat%0d_last", i), bq_last[i], i == 255);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                     ram_rd_en, ram_rd_addr, tdata, tvalid, tlast}, 0);
    endtask

    typedef struct {
        logic [11:0] addr;
        int          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
        logic        exp_en;
        logic [7:0]  exp_idx;
    } rd_vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [1:0]  exp_resp;
    } wr_vec_t;

    initial begin
        rd_vec_t rtab [9];
        wr_vec_t wtab [4];
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int lat, elat, accb;
        logic en1;
        logic [7:0] a1;
        logic [11:0] ra;

        rtab[0] = '{12'h008, 0, 32'd256,       2'b00, 1, 1'b0, 8'd0};
        rtab[1] = '{12'h004, 0, 32'd0,         2'b00, 1, 1'b0, 8'd0};
        rtab[2] = '{12'h414, 0, 32'h0000_0011, 2'b00, 2, 1'b1, 8'd5};
        rtab[3] = '{12'h800, 4, 32'd0,         2'b10, 1, 1'b0, 8'd0};
        rtab[4] = '{12'h000, 0, 32'd0,         2'b10, 1, 1'b0, 8'd0};
        rtab[5] = '{12'h400, 0, 32'hA500_0000, 2'b00, 2, 1'b1, 8'd0};
        rtab[6] = '{12'h7FC, 2, 32'hA500_00FF, 2'b00, 2, 1'b1, 8'd255};
        rtab[7] = '{12'h402, 0, 32'd0,         2'b10, 1, 1'b0, 8'd0};
        rtab[8] = '{12'hFFC, 0, 32'd0,         2'b10, 1, 1'b0, 8'd0};
        wtab[0] = '{12'h004, 32'd1, 2'b10};
        wtab[1] = '{12'h008, 32'd0, 2'b10};
        wtab[2] = '{12'h000, 32'd0, 2'b00};
        wtab[3] = '{12'h400, 32'd5, 2'b10};

        aresetn = 1'b0; awaddr = '0; araddr = '0; wdata = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b0;
        ram_rd_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        mem[5] = 32'h0000_0011;

        repeat (3) @(posedge aclk);
        #1;
        check_outputs_zero("reset_outputs");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check_outputs_zero("idle_outputs");

        for (int i = 0; i < 9; i++) begin
            axil_read(rtab[i].addr, rtab[i].hold, d, r, lat, accb, en1, a1);
            check($sformatf("rd_%0h_data", rtab[i].addr), d, rtab[i].exp_data);
            check($sformatf("rd_%0h_resp", rtab[i].addr), r, rtab[i].exp_resp);
            check($sformatf("rd_%0h_latency", rtab[i].addr), lat, rtab[i].exp_lat);
            check($sformatf("rd_%0h_ram_en", rtab[i].addr), en1, rtab[i].exp_en);
            if (rtab[i].exp_en) check($sformatf("rd_%0h_ram_addr", rtab[i].addr), a1, rtab[i].exp_idx);
        end
        for (int i = 0; i < 4; i++) begin
            axil_write(wtab[i].addr, wtab[i].data, r);
            check($sformatf("wr_%0h_resp", wtab[i].addr), r, wtab[i].exp_resp);
        end
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_after_non_start_writes", d, 0);
        check("no_beats_yet", bq_data.size(), 0);

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    ra = 12'h400 + 12'(4 * $urandom_range(0, 255));
                2:       ra = 12'h004;
                3:       ra = 12'h008;
                default: ra = 12'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) begin
                if (ra == 12'h000) ra = 12'h00C;
                axil_write(ra, $urandom, r);
                check("rand_wr_resp", r, 2'b10);
            end else begin
                axil_read(ra, $urandom_range(0, 2), d, r, lat, accb, en1, a1);
                model_read(ra, ed, er, elat);
                check($sformatf("rand_rd_%0h_data", ra), d, ed);
                check($sformatf("rand_rd_%0h_resp", ra), r, er);
                check($sformatf("rand_rd_%0h_latency", ra), lat, elat);
            end
        end

        for (int i = 0; i < 256; i++) mem[i] = i + 1;
        axil_write(12'h000, 32'd1, r);
        check("start1_resp", r, 2'b00);
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_busy", d, 32'h1);
        wait_beats(256);
        repeat (20) @(posedge aclk);
        #1;
        compare_dump();
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_done", d, 32'h2);

        bq_data.delete(); bq_last.delete();
        rand_mode = 1'b1;
        axil_write(12'h000, 32'd1, r);
        check("start2_resp", r, 2'b00);
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_done_cleared", d, 32'h1);
        wait_beats(50);
        axil_write(12'h000, 32'd1, r);
        check("start_while_busy_resp", r, 2'b00);
        axil_read(12'h414, 0, d, r, lat, accb, en1, a1);
        check("bin_read_stalled_until_idle", accb, 256);
        check("stalled_bin_data", d, 32'd6);
        check("stalled_bin_latency", lat, 2);
        repeat (30) @(posedge aclk);
        #1;
        compare_dump();
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_done_2", d, 32'h2);

        rand_mode = 1'b0;
        bq_data.delete(); bq_last.delete();
        axil_write(12'h000, 32'd1, r);
        wait_beats(100);
        aresetn = 1'b0;
        #1;
        check_outputs_zero("mid_dump_reset_outputs");
        repeat (5) @(posedge aclk);
        #1;
        check("no_beats_during_reset", bq_data.size(), 100);
        for (int i = 0; i < bq_data.size() && i < 100; i++) begin
            check($sformatf("abort_beat%0d_data", i), bq_data[i], mem[i]);
            check($sformatf("abort_beat%0d_last", i), bq_last[i], 1'b0);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        axil_read(12'h004, 0, d, r, lat, accb, en1, a1);
        check("status_after_reset", d, 0);
        bq_data.delete(); bq_last.delete();
        axil_write(12'h000, 32'd1, r);
        wait_beats(256);
        repeat (20) @(posedge aclk);
        #1;
        compare_dump();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
